// File: rtl/ram_latency_ctrl.sv
// Word-addressed RAM with a fixed access latency, reporting FREE/BUSY/ACCESS/ERROR.
// Optional one-entry read buffer enabled by defining RAM_READ_HIT_EN.
module ram_latency_ctrl #(
  parameter int unsigned LAT    = 2,
  parameter int unsigned ADDR_W = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam logic [3:0] LatCnt = 4'(LAT);

  ramstate_t   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_q, op_d;  // 1 = write
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] load_q;

  logic [31:0] mem [2**ADDR_W];

  logic              in_range, valid_req, any_req, illegal_req, changed;
  logic              do_access, hit_access, hit;
  logic [ADDR_W-1:0] req_idx, lat_idx;
  logic [31:0]       hit_data;

  assign in_range    = ~|ramaddr[31:ADDR_W+2];
  assign any_req     = ramREN | ramWEN;
  assign valid_req   = (ramREN ^ ramWEN) & in_range;
  assign illegal_req = any_req & ~valid_req;
  assign req_idx     = ramaddr[ADDR_W+1:2];
  assign lat_idx     = addr_q[ADDR_W+1:2];
  // Store data only matters for writes.
  assign changed     = (ramWEN != op_q) || (ramaddr != addr_q) ||
                       (ramWEN && (ramstore != data_q));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    do_access  = 1'b0;
    hit_access = 1'b0;
    case (state_q)
      BUSY: begin
        if (!any_req) begin
          state_d = FREE;
        end else if (illegal_req) begin
          state_d = ERROR;
        end else if (changed) begin
          op_d   = ramWEN;
          addr_d = ramaddr;
          data_d = ramstore;
          cnt_d  = LatCnt;
        end else if (cnt_q == 4'd1) begin
          state_d   = ACCESS;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      FREE, ACCESS, ERROR: begin
        if (valid_req) begin
          op_d   = ramWEN;
          addr_d = ramaddr;
          data_d = ramstore;
          cnt_d  = LatCnt;
          if (hit && (state_q != ERROR)) begin
            state_d    = ACCESS;
            hit_access = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end else if (illegal_req) begin
          state_d = ERROR;
        end else begin
          state_d = FREE;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FREE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      if (do_access && !op_q) begin
        load_q <= mem[lat_idx];
      end else if (hit_access) begin
        load_q <= hit_data;
      end
    end
  end

  // Array is never reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge CLK) begin
    if (!RST && do_access && op_q) begin
      mem[lat_idx] <= data_q;
    end
  end

`ifdef RAM_READ_HIT_EN
  logic              buf_vld_q;
  logic [ADDR_W-1:0] buf_idx_q;
  logic [31:0]       buf_data_q;

  assign hit      = ramREN && valid_req && buf_vld_q && (buf_idx_q == req_idx);
  assign hit_data = buf_data_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      buf_vld_q  <= 1'b0;
      buf_idx_q  <= '0;
      buf_data_q <= '0;
    end else if (do_access && !op_q) begin
      buf_vld_q  <= 1'b1;
      buf_idx_q  <= lat_idx;
      buf_data_q <= mem[lat_idx];
    end else if (do_access && op_q && buf_vld_q && (buf_idx_q == lat_idx)) begin
      buf_data_q <= data_q;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  assign ramstate = state_q;
  assign ramload  = load_q;

endmodule
